// File: rtl/ififo_feeder_if.sv
// Bus bundle between the input-FIFO feeder, the activation SRAM,
// the input FIFO bank and the job controller.
interface ififo_feeder_if #(
  parameter int col    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11
);
  logic              start;
  logic [addr_w-1:0] base_addr;
  logic [6:0]        num_rows;
  logic              sram_cen;
  logic [addr_w-1:0] sram_addr;
  logic [col*bw-1:0] sram_q;
  logic [col*bw-1:0] fifo_in;
  logic              fifo_wr;
  logic              fifo_full;
  logic              fifo_rd;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, num_rows,
    input  sram_q, fifo_full,
    output sram_cen, sram_addr,
    output fifo_in, fifo_wr, fifo_rd,
    output busy, done
  );

  modport slave (
    output start, base_addr, num_rows,
    output sram_q, fifo_full,
    input  sram_cen, sram_addr,
    input  fifo_in, fifo_wr, fifo_rd,
    input  busy, done
  );
endinterface

// File: rtl/ififo_feeder.sv
// Loads activation rows from SRAM into the input FIFO bank,
// then streams them out to the MAC array and signals completion.
module ififo_feeder #(
  parameter int col    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11,
  parameter int depth  = 64
) (
  input logic          clk,
  input logic          reset,
  ififo_feeder_if.master bus
);
  localparam int DW = col * bw;
  localparam int MX = (depth > col) ? depth : col;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] COL_M1 = CW'(col - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [2:0] {
    IDLE, FILL, STREAM, FLUSH, DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     n_q;
  logic [CW-1:0]     issued_q;
  logic [CW-1:0]     written_q;
  logic [CW-1:0]     cnt_q;
  logic [addr_w-1:0] addr_q;
  logic              rvalid_q;
  logic              skid_vld_q;
  logic [DW-1:0]     skid_q;
  logic              rd_q;
  logic              done_q;
  logic              busy_q;

  logic          issue;
  logic          wr;
  logic          last_wr;
  logic [CW-1:0] n_d;

  always_comb begin
    n_d = CW'(bus.num_rows);
    if (int'(bus.num_rows) > depth) begin
      n_d = CW'(depth);
    end
    // full gates the request in the same cycle, so at most one
    // returning word can ever be stranded and the skid never overflows
    issue = (state_q == FILL) && (issued_q < n_q)
         && !bus.fifo_full && !skid_vld_q;
    wr      = (rvalid_q || skid_vld_q) && !bus.fifo_full;
    last_wr = wr && ((written_q + ONE) == n_q);
  end

  assign bus.sram_cen  = !issue;
  assign bus.sram_addr = addr_q;
  assign bus.fifo_wr   = wr;
  assign bus.fifo_in   = skid_vld_q ? skid_q : bus.sram_q;
  assign bus.fifo_rd   = rd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      issued_q   <= '0;
      written_q  <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      rvalid_q   <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      rd_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rvalid_q <= issue;
      done_q   <= 1'b0;
      if (issue) begin
        addr_q   <= addr_q + addr_w'(1);
        issued_q <= issued_q + ONE;
      end
      if (rvalid_q && bus.fifo_full) begin
        skid_vld_q <= 1'b1;
        skid_q     <= bus.sram_q;
      end else if (skid_vld_q && !bus.fifo_full) begin
        skid_vld_q <= 1'b0;
      end
      if (wr) begin
        written_q <= written_q + ONE;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.start && (bus.num_rows != '0)) begin
            state_q   <= FILL;
            busy_q    <= 1'b1;
            n_q       <= n_d;
            addr_q    <= bus.base_addr;
            issued_q  <= '0;
            written_q <= '0;
            cnt_q     <= '0;
          end
        end
        FILL: begin
          if (last_wr) begin
            state_q <= STREAM;
            rd_q    <= 1'b1;
            cnt_q   <= ONE;
          end
        end
        STREAM: begin
          if (cnt_q == n_q) begin
            state_q <= FLUSH;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        FLUSH: begin
          if (cnt_q == COL_M1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
